// File: rtl/alu_arbiter_if.sv
// Shared ALU parameters and the requester/ALU bundle seen by alu_arbiter.
// The master modport is the requester and ALU side; the slave modport is the arbiter.
package alu_arbiter_pkg;
  parameter int ALU_OP_LENGTH = 4;
  parameter int DATA_W        = 32;
endpackage

interface alu_arbiter_if;
  import alu_arbiter_pkg::*;

  logic                     req0_valid;
  logic                     req0_ready;
  logic [ALU_OP_LENGTH-1:0] req0_opcode;
  logic [DATA_W-1:0]        req0_left;
  logic [DATA_W-1:0]        req0_right;

  logic                     req1_valid;
  logic                     req1_ready;
  logic [ALU_OP_LENGTH-1:0] req1_opcode;
  logic [DATA_W-1:0]        req1_left;
  logic [DATA_W-1:0]        req1_right;

  logic                     resp0_valid;
  logic                     resp0_ready;
  logic [DATA_W-1:0]        resp0_result;

  logic                     resp1_valid;
  logic                     resp1_ready;
  logic [DATA_W-1:0]        resp1_result;

  logic [ALU_OP_LENGTH-1:0] alu_opcode;
  logic [DATA_W-1:0]        alu_left;
  logic [DATA_W-1:0]        alu_right;
  logic [DATA_W-1:0]        alu_result;

  modport master (
    output req0_valid, req0_opcode, req0_left, req0_right,
    input  req0_ready,
    output req1_valid, req1_opcode, req1_left, req1_right,
    input  req1_ready,
    input  resp0_valid, resp0_result,
    output resp0_ready,
    input  resp1_valid, resp1_result,
    output resp1_ready,
    input  alu_opcode, alu_left, alu_right,
    output alu_result
  );

  modport slave (
    input  req0_valid, req0_opcode, req0_left, req0_right,
    output req0_ready,
    input  req1_valid, req1_opcode, req1_left, req1_right,
    output req1_ready,
    output resp0_valid, resp0_result,
    input  resp0_ready,
    output resp1_valid, resp1_result,
    input  resp1_ready,
    output alu_opcode, alu_left, alu_right,
    input  alu_result
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of a shared combinational ALU, with a
// registered issue stage and one response buffer per requester.
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input logic          clk,
  input logic          reset,
  alu_arbiter_if.slave bus
);

  logic                       s1_valid_q, s1_valid_d;
  logic                       s1_owner_q, s1_owner_d;
  logic [ALU_OP_LENGTH-1:0]   s1_opcode_q, s1_opcode_d;
  logic signed [DATA_W-1:0]   s1_left_q, s1_left_d;
  logic signed [DATA_W-1:0]   s1_right_q, s1_right_d;
  logic                       last_grant_q, last_grant_d;

  logic [1:0]                 resp_valid_q, resp_valid_d;
  logic signed [DATA_W-1:0]   resp0_result_q, resp0_result_d;
  logic signed [DATA_W-1:0]   resp1_result_q, resp1_result_d;

  logic [1:0] req_valid;
  logic [1:0] resp_ready;
  logic [1:0] inflight;
  logic [1:0] eligible;
  logic [1:0] cand;
  logic [1:0] grant;
  logic [1:0] capture;

  assign req_valid  = {bus.req1_valid, bus.req0_valid};
  assign resp_ready = {bus.resp1_ready, bus.resp0_ready};

  // A port may issue only when nothing of its own is in S1 and its buffer
  // is free or being drained this cycle, so a capture never clobbers a result.
  always_comb begin
    inflight = {s1_valid_q & s1_owner_q, s1_valid_q & ~s1_owner_q};
    eligible = ~inflight & (~resp_valid_q | resp_ready);
    cand     = req_valid & eligible;
    grant    = 2'b00;
    if (!reset) begin
      grant[0] = cand[0] & (~cand[1] | last_grant_q);
      grant[1] = cand[1] & (~cand[0] | ~last_grant_q);
    end
  end

  always_comb begin
    s1_valid_d   = |grant;
    s1_owner_d   = s1_owner_q;
    s1_opcode_d  = s1_opcode_q;
    s1_left_d    = s1_left_q;
    s1_right_d   = s1_right_q;
    last_grant_d = last_grant_q;
    if (grant[0]) begin
      s1_owner_d   = 1'b0;
      s1_opcode_d  = bus.req0_opcode;
      s1_left_d    = bus.req0_left;
      s1_right_d   = bus.req0_right;
      last_grant_d = 1'b0;
    end else if (grant[1]) begin
      s1_owner_d   = 1'b1;
      s1_opcode_d  = bus.req1_opcode;
      s1_left_d    = bus.req1_left;
      s1_right_d   = bus.req1_right;
      last_grant_d = 1'b1;
    end
  end

  // The ALU result belongs to whoever owns S1; capture takes priority over drain.
  always_comb begin
    capture        = inflight;
    resp_valid_d   = capture | (resp_valid_q & ~resp_ready);
    resp0_result_d = capture[0] ? bus.alu_result : resp0_result_q;
    resp1_result_d = capture[1] ? bus.alu_result : resp1_result_q;
  end

  // ---- S1 issue stage / response buffers ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q     <= 1'b0;
      s1_owner_q     <= 1'b0;
      s1_opcode_q    <= '0;
      s1_left_q      <= '0;
      s1_right_q     <= '0;
      last_grant_q   <= 1'b1;
      resp_valid_q   <= 2'b00;
      resp0_result_q <= '0;
      resp1_result_q <= '0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_owner_q     <= s1_owner_d;
      s1_opcode_q    <= s1_opcode_d;
      s1_left_q      <= s1_left_d;
      s1_right_q     <= s1_right_d;
      last_grant_q   <= last_grant_d;
      resp_valid_q   <= resp_valid_d;
      resp0_result_q <= resp0_result_d;
      resp1_result_q <= resp1_result_d;
    end
  end

  assign bus.req0_ready   = grant[0];
  assign bus.req1_ready   = grant[1];
  assign bus.resp0_valid  = resp_valid_q[0];
  assign bus.resp1_valid  = resp_valid_q[1];
  assign bus.resp0_result = resp0_result_q;
  assign bus.resp1_result = resp1_result_q;
  assign bus.alu_opcode   = s1_opcode_q;
  assign bus.alu_left     = s1_left_q;
  assign bus.alu_right    = s1_right_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: an operation-level model of both requesters and their
// buffers, checked every cycle, plus directed scenarios with literal results.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_arbiter_if bus();

  alu_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_XOR = 4'd4,
                         OP_SLT = 4'd5, OP_SLTU = 4'd6, OP_SRA = 4'd9;

  function automatic logic [31:0] alu_ref(input logic [ALU_OP_LENGTH-1:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: return (a < b) ? 32'd1 : 32'd0;
      4'd7: return a << b[4:0];
      4'd8: return a >> b[4:0];
      4'd9: return 32'($signed(a) >>> b[4:0]);
      default: return 32'd0;
    endcase
  endfunction

  always_comb bus.alu_result = alu_ref(bus.alu_opcode, bus.alu_left, bus.alu_right);

  // model: one issued op (owner + its eventual result) and two result buffers
  bit          m_s1v;
  bit          m_s1o;
  logic [3:0]  m_op;
  logic [31:0] m_l, m_r, m_s1res;
  bit          m_last;
  bit          m_rv [2];
  logic [31:0] m_rr [2];

  int n_chk = 0;
  int n_fail = 0;
  int last_g;
  bit r0_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_s1v = 0; m_s1o = 0; m_op = '0; m_l = '0; m_r = '0; m_s1res = '0;
    m_last = 1;
    m_rv[0] = 0; m_rv[1] = 0; m_rr[0] = '0; m_rr[1] = '0;
  endtask

  task automatic set_req(input int p, input bit v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_opcode = op; bus.req0_left = a; bus.req0_right = b;
    end else begin
      bus.req1_valid = v; bus.req1_opcode = op; bus.req1_left = a; bus.req1_right = b;
    end
  endtask

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic step();
    bit e0, e1, c0, c1, g0, g1, cap0, cap1;
    if (reset) model_clear();
    #1;
    e0 = !(m_s1v && m_s1o == 0) && (!m_rv[0] || bus.resp0_ready);
    e1 = !(m_s1v && m_s1o == 1) && (!m_rv[1] || bus.resp1_ready);
    c0 = bus.req0_valid && e0 && !reset;
    c1 = bus.req1_valid && e1 && !reset;
    g0 = c0 && (!c1 || m_last == 1);
    g1 = c1 && (!c0 || m_last == 0);
    chk("req0_ready", bus.req0_ready, g0);
    chk("req1_ready", bus.req1_ready, g1);
    chk("resp0_valid", bus.resp0_valid, m_rv[0]);
    chk("resp1_valid", bus.resp1_valid, m_rv[1]);
    chk("resp0_result", bus.resp0_result, m_rr[0]);
    chk("resp1_result", bus.resp1_result, m_rr[1]);
    chk("alu_opcode", 32'(bus.alu_opcode), 32'(m_op));
    chk("alu_left", bus.alu_left, m_l);
    chk("alu_right", bus.alu_right, m_r);
    last_g  = g0 ? 0 : (g1 ? 1 : -1);
    r0_seen = bus.req0_ready;
    @(posedge clk);
    if (reset) model_clear();
    else begin
      cap0 = m_s1v && m_s1o == 0;
      cap1 = m_s1v && m_s1o == 1;
      if (m_rv[0] && bus.resp0_ready && !cap0) m_rv[0] = 0;
      if (m_rv[1] && bus.resp1_ready && !cap1) m_rv[1] = 0;
      if (cap0) begin m_rv[0] = 1; m_rr[0] = m_s1res; end
      if (cap1) begin m_rv[1] = 1; m_rr[1] = m_s1res; end
      if (g0) begin
        m_s1v = 1; m_s1o = 0; m_op = bus.req0_opcode; m_l = bus.req0_left; m_r = bus.req0_right;
        m_s1res = alu_ref(m_op, m_l, m_r); m_last = 0;
      end else if (g1) begin
        m_s1v = 1; m_s1o = 1; m_op = bus.req1_opcode; m_l = bus.req1_left; m_r = bus.req1_right;
        m_s1res = alu_ref(m_op, m_l, m_r); m_last = 1;
      end else m_s1v = 0;
    end
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    set_req(0, 0, '0, '0, '0);
    set_req(1, 0, '0, '0, '0);
    bus.resp0_ready = 0;
    bus.resp1_ready = 0;
    model_clear();
    @(negedge clk);
    bus.req0_valid = 1;
    step();
    chk("reset_resp0_valid", bus.resp0_valid, 0);
    chk("reset_alu_left", bus.alu_left, 0);
    chk("reset_no_grant", last_g, -1);
    reset = 1'b0;
    bus.req0_valid = 0;
    step();

    // single op
    set_req(0, 1, OP_ADD, 32'd5, 32'd7);
    step();
    chk("single_grant", last_g, 0);
    set_req(0, 0, OP_ADD, 32'd5, 32'd7);
    step();
    chk("single_resp0_valid", bus.resp0_valid, 1);
    chk("single_resp0_result", bus.resp0_result, 32'd12);
    chk("single_resp1_valid", bus.resp1_valid, 0);
    bus.resp0_ready = 1;
    step();

    // tie / round-robin from reset
    reset_pulse();
    bus.resp0_ready = 1; bus.resp1_ready = 1;
    set_req(0, 1, OP_SUB, 32'd10, 32'd3);
    set_req(1, 1, OP_XOR, 32'hF0, 32'h0F);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_grant", last_g, k % 2);
      if (k == 1) chk("rr_res0", bus.resp0_result, 32'd7);
      if (k == 2) chk("rr_res1", bus.resp1_result, 32'hFF);
    end

    // backpressure
    reset_pulse();
    bus.resp0_ready = 0; bus.resp1_ready = 1;
    set_req(0, 1, OP_SLT, 32'hFFFF_FFFF, 32'd1);
    set_req(1, 1, OP_ADD, 32'd2, 32'd3);
    step();
    chk("bp_first_grant", last_g, 0);
    set_req(0, 1, OP_ADD, 32'd100, 32'd1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_r0_blocked", r0_seen, 0);
      chk("bp_r1_alt", last_g, (k % 2 == 0) ? 1 : -1);
    end
    chk("bp_resp0_result", bus.resp0_result, 32'd1);
    bus.resp0_ready = 1;
    step();
    chk("bp_r0_accept", r0_seen, 1);
    set_req(0, 0, OP_ADD, 0, 0);
    set_req(1, 0, OP_ADD, 0, 0);
    step();
    chk("bp_new_result", bus.resp0_result, 32'd101);

    // shift / sign
    set_req(1, 1, OP_SRA, 32'h8000_0000, 32'd4);
    step();
    set_req(1, 0, OP_SRA, 0, 0);
    step();
    chk("sra", bus.resp1_result, 32'hF800_0000);
    set_req(1, 1, OP_SLTU, 32'hFFFF_FFFF, 32'd1);
    step();
    set_req(1, 0, OP_SLTU, 0, 0);
    step();
    chk("sltu_valid", bus.resp1_valid, 1);
    chk("sltu", bus.resp1_result, 32'd0);
    step();

    // reset mid-flight
    bus.resp0_ready = 0;
    set_req(0, 1, OP_ADD, 32'd1, 32'd1);
    step();
    chk("mid_grant", last_g, 0);
    set_req(0, 0, OP_ADD, 0, 0);
    reset = 1'b1;
    step();
    chk("mid_resp0_valid", bus.resp0_valid, 0);
    chk("mid_alu_left", bus.alu_left, 0);
    chk("mid_alu_opcode", 32'(bus.alu_opcode), 0);
    reset = 1'b0;
    step();
    chk("mid_no_late_resp", bus.resp0_valid, 0);
    set_req(0, 1, OP_XOR, 32'd3, 32'd5);
    set_req(1, 1, OP_ADD, 32'd3, 32'd5);
    step();
    chk("mid_tie_req0", last_g, 0);

    // idle
    set_req(0, 0, OP_ADD, 0, 0);
    set_req(1, 0, OP_ADD, 0, 0);
    bus.resp0_ready = 0; bus.resp1_ready = 0;
    for (int k = 0; k < 10; k++) step();
    chk("idle_alu_left", bus.alu_left, 32'd3);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      set_req(0, ($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)), $urandom(), $urandom());
      set_req(1, ($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)), $urandom(), $urandom());
      bus.resp0_ready = ($urandom_range(0, 9) < 6);
      bus.resp1_ready = ($urandom_range(0, 9) < 6);
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
